si570_freq_sequencer: RTL

SI570_FREQ_SEQUENCER -- requirements
Module: si570_freq_sequencer

---
 rtl/si570_freq_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/si570_freq_sequencer.sv
// Si570 user-clock reprogramming sequencer.
// Runs the freeze / write HS_DIV-N1-RFREQ / unfreeze / NewFreq sequence as
// five single I2C write transactions. Failed steps are retried on NACK up to a
// bounded count.
module si570_freq_sequencer #(
  parameter logic [6:0]  SlaveAddress = 7'h5D,
  parameter int unsigned MaxRetries   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [47:0] i_cfg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_step,
  output logic        o_rv0_valid,
  input  logic        i_rv0_ready,
  output logic [6:0]  o_rv0_slave_address,
  output logic [31:0] o_rv0_wdata,
  output logic [1:0]  o_rv0_burst_count_wr,
  output logic [1:0]  o_rv0_burst_count_rd,
  output logic        o_rv0_rd_wrn,
  input  logic        i_rv1_valid,
  output logic        o_rv1_ready,
  input  logic        i_rv1_nack,
  input  logic [31:0] i_rv1_rdata
);

  localparam int unsigned     RetryW   = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);
  localparam logic [2:0]      LastStep = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [2:0]          r_step;
  logic [2:0]          w_step_nxt;
  logic [RetryW-1:0]   r_retry;
  logic [RetryW-1:0]   w_retry_nxt;
  logic [47:0]         r_cfg;
  logic [47:0]         w_cfg_nxt;
  logic                r_error;
  logic                w_error_nxt;

  logic                r_busy;
  logic                r_done;
  logic                r_rv0_valid;
  logic                r_rv1_ready;
  logic [31:0]         r_wdata;
  logic [1:0]          r_burst;

  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_rv0_valid_nxt;
  logic                w_rv1_ready_nxt;
  logic [31:0]         w_wdata_nxt;
  logic [1:0]          w_burst_nxt;

  // Response payload carries nothing useful for a write-only sequence.
  logic                w_unused_rdata;
  assign w_unused_rdata = ^i_rv1_rdata;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and sequencing bookkeeping (step, retries, latched config, error flag).
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_retry_nxt = r_retry;
    w_cfg_nxt   = r_cfg;
    w_error_nxt = r_error;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_ISSUE;
          w_step_nxt  = '0;
          w_retry_nxt = '0;
          w_cfg_nxt   = i_cfg;
          w_error_nxt = 1'b0;
        end
      end
      S_ISSUE: begin
        if (r_rv0_valid && i_rv0_ready) begin
          w_state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (i_rv1_valid) begin
          if (!i_rv1_nack) begin
            if (r_step == LastStep) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_ISSUE;
              w_step_nxt  = r_step + 3'd1;
              w_retry_nxt = '0;
            end
          end else if (r_retry < RetryMax) begin
            w_state_nxt = S_ISSUE;
            w_retry_nxt = r_retry + RetryW'(1);
          end else begin
            w_state_nxt = S_ERROR;
            w_error_nxt = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output can be registered
  // without adding a cycle of latency; payload is only reloaded on entry to ISSUE.
  always_comb begin
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_rv0_valid_nxt = (w_state_nxt == S_ISSUE);
    w_rv1_ready_nxt = (w_state_nxt == S_WAIT_RESP);
    w_wdata_nxt     = r_wdata;
    w_burst_nxt     = r_burst;
    if (w_state_nxt == S_ISSUE) begin
      unique case (w_step_nxt)
        3'd0: begin
          w_wdata_nxt = {16'h0000, 8'h10, 8'd137};
          w_burst_nxt = 2'd1;
        end
        3'd1: begin
          w_wdata_nxt = {w_cfg_nxt[31:24], w_cfg_nxt[39:32], w_cfg_nxt[47:40], 8'd7};
          w_burst_nxt = 2'd3;
        end
        3'd2: begin
          w_wdata_nxt = {w_cfg_nxt[7:0], w_cfg_nxt[15:8], w_cfg_nxt[23:16], 8'd10};
          w_burst_nxt = 2'd3;
        end
        3'd3: begin
          w_wdata_nxt = {16'h0000, 8'h00, 8'd137};
          w_burst_nxt = 2'd1;
        end
        3'd4: begin
          w_wdata_nxt = {16'h0000, 8'h40, 8'd135};
          w_burst_nxt = 2'd1;
        end
        default: begin
          w_wdata_nxt = '0;
          w_burst_nxt = '0;
        end
      endcase
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_step      <= '0;
      r_retry     <= '0;
      r_cfg       <= '0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rv0_valid <= 1'b0;
      r_rv1_ready <= 1'b0;
      r_wdata     <= '0;
      r_burst     <= '0;
    end else begin
      r_step      <= w_step_nxt;
      r_retry     <= w_retry_nxt;
      r_cfg       <= w_cfg_nxt;
      r_error     <= w_error_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rv0_valid <= w_rv0_valid_nxt;
      r_rv1_ready <= w_rv1_ready_nxt;
      r_wdata     <= w_wdata_nxt;
      r_burst     <= w_burst_nxt;
    end
  end

  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_error              = r_error;
  assign o_step               = r_step;
  assign o_rv0_valid          = r_rv0_valid;
  assign o_rv1_ready          = r_rv1_ready;
  assign o_rv0_wdata          = r_wdata;
  assign o_rv0_burst_count_wr = r_burst;
  assign o_rv0_burst_count_rd = 2'd0;
  assign o_rv0_rd_wrn         = 1'b0;
  assign o_rv0_slave_address  = SlaveAddress;

endmodule
